// File: rtl/keypad_scan.sv
// 4x4 keypad matrix scanner: column drive, row synchronizer, frame-based debounce
// and a small key-code FIFO with falling-edge read strobe.
module keypad_scan #(
    parameter int SCAN_DIV   = 50000,
    parameter int DEB_FRAMES = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    input  logic       rdn,
    output logic [4:0] keyCode,
    output logic       keyReady,
    output logic       overflow
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W = $clog2(DEB_FRAMES + 2);
    localparam int AW    = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAND,
        S_HELD,
        S_REL
    } state_t;

    logic [3:0]       r_sync1, r_sync2;
    logic [CNT_W-1:0] r_scan_cnt;
    logic [1:0]       r_col_idx;
    logic [3:0]       r_col_out;
    logic [15:0]      r_frame;

    state_t           r_state;
    logic [DEB_W-1:0] r_deb_cnt;
    logic [3:0]       r_cand;

    logic [3:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [AW:0]      r_count;
    logic             r_rdn_q;
    logic             r_overflow;

    logic             w_slot_end, w_frame_done;
    logic [1:0]       w_col_nxt;
    logic [15:0]      w_frame_full;
    logic [4:0]       w_ones;
    logic [3:0]       w_code;
    logic             w_single, w_none;
    logic [DEB_W-1:0] w_cnt_inc;
    logic             w_deb_done;
    logic             w_push, w_pop, w_wr, w_full, w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 4'hF;
            r_sync2 <= 4'hF;
        end else begin
            r_sync1 <= row_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_slot_end   = (r_scan_cnt == CNT_W'(SCAN_DIV - 1));
    assign w_frame_done = w_slot_end && (r_col_idx == 2'd3);
    assign w_col_nxt    = r_col_idx + 2'd1;

    // Frame bit index {row, col} doubles as the 4-bit key code.
    always_comb begin
        w_frame_full = r_frame;
        for (int unsigned r = 0; r < 4; r++) begin
            if (!r_sync2[r]) w_frame_full[{r[1:0], r_col_idx}] = 1'b1;
        end
    end

    always_comb begin
        w_ones = '0;
        w_code = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (w_frame_full[i]) begin
                w_ones = w_ones + 5'd1;
                w_code = i[3:0];
            end
        end
    end

    assign w_single = (w_ones == 5'd1);
    assign w_none   = (w_ones == 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_col_idx  <= '0;
            r_col_out  <= 4'b1110;
            r_frame    <= '0;
        end else if (w_slot_end) begin
            r_scan_cnt <= '0;
            r_col_idx  <= w_col_nxt;
            r_col_out  <= ~(4'b0001 << w_col_nxt);
            r_frame    <= w_frame_done ? '0 : w_frame_full;
        end else begin
            r_scan_cnt <= r_scan_cnt + CNT_W'(1);
        end
    end

    assign w_cnt_inc  = r_deb_cnt + DEB_W'(1);
    assign w_deb_done = (w_cnt_inc >= DEB_W'(DEB_FRAMES));
    assign w_push     = w_frame_done && (r_state == S_CAND) && w_single
                        && (w_code == r_cand) && w_deb_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_deb_cnt <= '0;
            r_cand    <= '0;
        end else if (w_frame_done) begin
            case (r_state)
                S_IDLE: begin
                    if (w_single) begin
                        r_cand    <= w_code;
                        r_deb_cnt <= DEB_W'(1);
                        r_state   <= S_CAND;
                    end
                end
                S_CAND: begin
                    if (w_single && (w_code == r_cand)) begin
                        r_deb_cnt <= w_cnt_inc;
                        if (w_deb_done) r_state <= S_HELD;
                    end else if (w_single) begin
                        r_cand    <= w_code;
                        r_deb_cnt <= DEB_W'(1);
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_HELD: begin
                    if (w_none) begin
                        r_deb_cnt <= DEB_W'(1);
                        r_state   <= S_REL;
                    end
                end
                S_REL: begin
                    if (w_none) begin
                        r_deb_cnt <= w_cnt_inc;
                        if (w_deb_done) r_state <= S_IDLE;
                    end else begin
                        r_state <= S_HELD;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (AW + 1)'(FIFO_DEPTH));
    assign w_pop   = r_rdn_q && !rdn && !w_empty;
    // A full FIFO still accepts a push when a pop frees the head in the same cycle.
    assign w_wr    = !rst && w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= r_cand;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_rdn_q    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_rdn_q <= rdn;
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            if (w_wr)  r_wptr <= r_wptr + AW'(1);
            if (w_wr && !w_pop)      r_count <= r_count + (AW + 1)'(1);
            else if (w_pop && !w_wr) r_count <= r_count - (AW + 1)'(1);
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    always_comb begin
        col_out  = r_col_out;
        keyReady = !w_empty;
        keyCode  = w_empty ? 5'h00 : {1'b0, r_mem[r_rptr]};
        overflow = r_overflow;
    end

endmodule
